ag32gbd_frame_scanner: RTL and testbench

//  Frame-level driver for ag32gbd_sampler: walks every pixel of a WIDTH x HEIGHT frame.
//  For each pixel: issues a SampleStart handshake, collects the 2-bit SampledValue,

---
 rtl/ag32gbd_frame_scanner.sv | 176 +++++++++++++++++
 tb/tb_ag32gbd_frame_scanner.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ag32gbd_frame_scanner.sv
// Frame scanner: walks every pixel of the frame, requests one sample per pixel,
// packs the 2-bit results into 2bpp tile bytes and writes them to the frame BRAM.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for FrameStart
// S_ARM     | waiting for the previous SampleDone stretch to expire
// S_REQ     | SampleStart held, waiting for SampleDone rise or timeout
// S_CAPTURE | shift the captured pixel into the plane registers
// S_WR_LO   | write low-plane byte of the current tile row
// S_WR_HI   | write high-plane byte of the current tile row
// S_NEXT    | advance to the next pixel or finish the frame
// S_DONE    | one-cycle FrameDone pulse
module ag32gbd_frame_scanner #(
    parameter int          WIDTH     = 128,
    parameter int          HEIGHT    = 112,
    parameter logic [11:0] BASE_ADDR = 12'h000,
    parameter logic [15:0] TIMEOUT   = 16'd4095
) (
    input  logic        sys_clock,
    input  logic        sys_resetn,
    input  logic        FrameStart,
    input  logic        FrameAbort,
    output logic        Busy,
    output logic        FrameDone,
    output logic        TimeoutErr,
    output logic        SampleStart,
    output logic [6:0]  PixelX,
    output logic [6:0]  PixelY,
    input  logic        SampleDone,
    input  logic [1:0]  SampledValue,
    output logic        WrEn,
    output logic [11:0] WrAddr,
    output logic [7:0]  WrData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_REQ,
        S_CAPTURE,
        S_WR_LO,
        S_WR_HI,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [6:0]  X_LAST  = 7'(WIDTH - 1);
    localparam logic [6:0]  Y_LAST  = 7'(HEIGHT - 1);
    localparam logic [11:0] TILES_X = 12'(WIDTH / 8);

    state_t      state, next_state;
    logic [6:0]  pixel_x, pixel_y;
    logic [7:0]  plane_lo, plane_hi;
    logic [1:0]  sample_val;
    logic [15:0] tmo_cnt;
    logic        done_r, done_d;
    logic        timeout_err;
    logic        done_rise, tmo_hit;
    logic [11:0] tile_idx, addr_lo;

    assign done_rise = done_r & ~done_d;
    assign tmo_hit   = (tmo_cnt == 16'd0);

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:    if (FrameStart) next_state = S_ARM;
            S_ARM:     if (!SampleDone) next_state = S_REQ;
            S_REQ:     if (done_rise || tmo_hit) next_state = S_CAPTURE;
            S_CAPTURE: next_state = (pixel_x[2:0] == 3'd7) ? S_WR_LO : S_NEXT;
            S_WR_LO:   next_state = S_WR_HI;
            S_WR_HI:   next_state = S_NEXT;
            S_NEXT:    next_state = (pixel_x == X_LAST && pixel_y == Y_LAST) ? S_DONE : S_ARM;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
        if (FrameAbort) next_state = S_IDLE;
    end

    // Timeout is a down-counter loaded on arming; terminal count at zero.
    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            plane_lo    <= '0;
            plane_hi    <= '0;
            sample_val  <= '0;
            tmo_cnt     <= '0;
            done_r      <= 1'b0;
            done_d      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done_r <= SampleDone;
            done_d <= done_r;
            if (FrameAbort) begin
                plane_lo <= '0;
                plane_hi <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (FrameStart) begin
                            pixel_x     <= '0;
                            pixel_y     <= '0;
                            plane_lo    <= '0;
                            plane_hi    <= '0;
                            timeout_err <= 1'b0;
                        end
                    end
                    S_ARM: begin
                        if (!SampleDone) tmo_cnt <= TIMEOUT;
                    end
                    S_REQ: begin
                        if (done_rise) begin
                            sample_val <= SampledValue;
                        end else if (tmo_hit) begin
                            sample_val  <= 2'b00;
                            timeout_err <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt - 16'd1;
                        end
                    end
                    S_CAPTURE: begin
                        plane_lo <= {plane_lo[6:0], sample_val[0]};
                        plane_hi <= {plane_hi[6:0], sample_val[1]};
                    end
                    S_NEXT: begin
                        if (pixel_x == X_LAST) begin
                            if (pixel_y != Y_LAST) begin
                                pixel_x <= '0;
                                pixel_y <= pixel_y + 7'd1;
                            end
                        end else begin
                            pixel_x <= pixel_x + 7'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tile_idx = {5'b0, pixel_y[6:3]} * TILES_X + {8'b0, pixel_x[6:3]};
    assign addr_lo  = BASE_ADDR + {tile_idx[7:0], 4'b0} + {8'b0, pixel_y[2:0], 1'b0};

    always_comb begin
        Busy        = (state != S_IDLE) && (state != S_DONE);
        FrameDone   = (state == S_DONE);
        SampleStart = (state == S_REQ);
        WrEn        = 1'b0;
        WrAddr      = '0;
        WrData      = '0;
        if (state == S_WR_LO) begin
            WrEn   = 1'b1;
            WrAddr = addr_lo;
            WrData = plane_lo;
        end else if (state == S_WR_HI) begin
            WrEn   = 1'b1;
            WrAddr = addr_lo + 12'd1;
            WrData = plane_hi;
        end
    end

    assign TimeoutErr = timeout_err;
    assign PixelX     = pixel_x;
    assign PixelY     = pixel_y;

endmodule

// File: tb/tb_ag32gbd_frame_scanner.sv
// Bench for ag32gbd_frame_scanner: randomized-latency sampler model plus a
// tile-packing reference model built from plain loops over the frame.
module tb_ag32gbd_frame_scanner;

    localparam int          W    = 32;
    localparam int          H    = 16;
    localparam logic [11:0] BASE = 12'h000;
    localparam int          TO   = 16;

    logic        clk, rstn;
    logic        FrameStart, FrameAbort;
    logic        Busy, FrameDone, TimeoutErr, SampleStart;
    logic [6:0]  PixelX, PixelY;
    logic        SampleDone;
    logic [1:0]  SampledValue;
    logic        WrEn;
    logic [11:0] WrAddr;
    logic [7:0]  WrData;

    int errors = 0;
    int checks = 0;
    int mode   = 0;
    int seed   = 0;
    bit mute_en = 0;
    int mute_x = 0;
    int mute_y = 0;
    int done_cnt = 0;
    logic [11:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];

    ag32gbd_frame_scanner #(
        .WIDTH(W), .HEIGHT(H), .BASE_ADDR(BASE), .TIMEOUT(16'(TO))
    ) dut (
        .sys_clock(clk), .sys_resetn(rstn),
        .FrameStart(FrameStart), .FrameAbort(FrameAbort),
        .Busy(Busy), .FrameDone(FrameDone), .TimeoutErr(TimeoutErr),
        .SampleStart(SampleStart), .PixelX(PixelX), .PixelY(PixelY),
        .SampleDone(SampleDone), .SampledValue(SampledValue),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1:0] ref_val(input int x, input int y);
        if (mute_en && x == mute_x && y == mute_y) return 2'b00;
        case (mode)
            0:       return 2'(x % 4);
            1:       return 2'b11;
            default: return 2'((x * 5 + y * 3 + seed) % 4);
        endcase
    endfunction

    // Sampler model: random answer latency and random done stretch.
    initial begin
        int delay, stretch;
        bit ss_prev;
        logic [1:0] pend;
        SampleDone = 1'b0; SampledValue = 2'b00;
        delay = 0; stretch = 0; ss_prev = 1'b0; pend = 2'b00;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                delay = 0; stretch = 0; ss_prev = 1'b0; SampleDone = 1'b0;
            end else begin
                if (stretch > 0) begin
                    stretch--;
                    if (stretch == 0) SampleDone = 1'b0;
                end
                if (SampleStart && !ss_prev) begin
                    if (!(mute_en && PixelX == 7'(mute_x) && PixelY == 7'(mute_y))) begin
                        delay = $urandom_range(1, 3);
                        pend  = ref_val(PixelX, PixelY);
                    end
                end else if (!SampleStart) begin
                    delay = 0;
                end else if (delay > 0) begin
                    delay--;
                    if (delay == 0) begin
                        SampleDone   = 1'b1;
                        SampledValue = pend;
                        stretch      = $urandom_range(1, 4);
                    end
                end
                ss_prev = SampleStart;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (WrEn) begin
                wr_addr_q.push_back(WrAddr);
                wr_data_q.push_back(WrData);
            end
            if (FrameDone) done_cnt++;
        end
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        FrameStart = 1'b1;
        @(negedge clk);
        FrameStart = 1'b0;
    endtask

    task automatic run_to_done(input string name);
        int n = 0;
        while (FrameDone !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (FrameDone !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: FrameDone=%b after %0d cycles, required 1", name, FrameDone, n);
        end
    endtask

    task automatic wait_pixel(input string name, input int x, input int y);
        int n = 0;
        while (!(PixelX == 7'(x) && PixelY == 7'(y)) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(PixelX == 7'(x) && PixelY == 7'(y))) begin
            errors++;
            $display("FAIL %s_reach: pixel (%0d,%0d), required (%0d,%0d)", name, PixelX, PixelY, x, y);
        end
    endtask

    task automatic compare_frame(input string name);
        logic [11:0] ea[$];
        logic [7:0]  ed[$];
        logic [7:0]  lo, hi;
        logic [1:0]  v;
        int mism = 0;
        int first = -1;
        for (int y = 0; y < H; y++) begin
            for (int tx = 0; tx < W / 8; tx++) begin
                lo = 8'h00; hi = 8'h00;
                for (int b = 0; b < 8; b++) begin
                    v = ref_val(tx * 8 + b, y);
                    lo[7 - b] = v[0];
                    hi[7 - b] = v[1];
                end
                ea.push_back(12'(int'(BASE) + ((y / 8) * (W / 8) + tx) * 16 + (y % 8) * 2));
                ed.push_back(lo);
                ea.push_back(12'(int'(BASE) + ((y / 8) * (W / 8) + tx) * 16 + (y % 8) * 2 + 1));
                ed.push_back(hi);
            end
        end
        checks++;
        if (wr_addr_q.size() != ea.size()) begin
            mism++;
        end else begin
            foreach (ea[i]) begin
                if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
                    mism++;
                    if (first < 0) first = i;
                end
            end
        end
        if (mism != 0) begin
            errors++;
            $display("FAIL %s_frame: %0d writes with %0d bad (first idx %0d), required %0d writes matching model",
                     name, wr_addr_q.size(), mism, first, ea.size());
        end
    endtask

    function automatic int find_byte(input logic [11:0] a);
        foreach (wr_addr_q[i]) if (wr_addr_q[i] == a) return int'(wr_data_q[i]);
        return -1;
    endfunction

    task automatic test_reset();
        rstn = 1'b0; FrameStart = 1'b0; FrameAbort = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (Busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b, required 0", Busy); end
        checks++; if (FrameDone !== 1'b0)   begin errors++; $display("FAIL rst_done: got %b, required 0", FrameDone); end
        checks++; if (TimeoutErr !== 1'b0)  begin errors++; $display("FAIL rst_tmo: got %b, required 0", TimeoutErr); end
        checks++; if (SampleStart !== 1'b0) begin errors++; $display("FAIL rst_ss: got %b, required 0", SampleStart); end
        checks++; if (WrEn !== 1'b0)        begin errors++; $display("FAIL rst_wren: got %b, required 0", WrEn); end
        checks++; if (PixelX !== 7'd0 || PixelY !== 7'd0) begin
            errors++; $display("FAIL rst_pixel: got (%0d,%0d), required (0,0)", PixelX, PixelY);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ramp();
        int b0, b1;
        mode = 0; mute_en = 0;
        clear_log();
        pulse_start();
        run_to_done("ramp");
        repeat (3) @(negedge clk);
        compare_frame("ramp");
        b0 = find_byte(12'h000);
        b1 = find_byte(12'h001);
        checks++; if (b0 != 32'h55) begin errors++; $display("FAIL ramp_b0: got %0h, required 55", b0); end
        checks++; if (b1 != 32'h33) begin errors++; $display("FAIL ramp_b1: got %0h, required 33", b1); end
        checks++; if (wr_addr_q.size() != W * H / 4) begin
            errors++; $display("FAIL ramp_count: got %0d, required %0d", wr_addr_q.size(), W * H / 4);
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ramp_donecnt: got %0d, required 1", done_cnt); end
        checks++; if (TimeoutErr !== 1'b0) begin errors++; $display("FAIL ramp_tmo: got %b, required 0", TimeoutErr); end
    endtask

    task automatic test_const();
        int bad = 0;
        logic [11:0] last_exp;
        mode = 1; mute_en = 0;
        clear_log();
        pulse_start();
        run_to_done("const");
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL const_busy_done: got %b, required 0", Busy); end
        @(negedge clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL const_busy_after: got %b, required 0", Busy); end
        foreach (wr_data_q[i]) if (wr_data_q[i] !== 8'hFF) bad++;
        checks++; if (bad != 0 || wr_data_q.size() == 0) begin
            errors++; $display("FAIL const_data: %0d of %0d bytes not FF, required all FF", bad, wr_data_q.size());
        end
        last_exp = 12'(int'(BASE) + ((H / 8) * (W / 8) - 1) * 16 + 15);
        checks++; if (wr_addr_q.size() == 0 || wr_addr_q[$] !== last_exp) begin
            errors++; $display("FAIL const_last_addr: got %0h, required %0h",
                               (wr_addr_q.size() == 0) ? 12'h0 : wr_addr_q[$], last_exp);
        end
        compare_frame("const");
    endtask

    task automatic test_timeout();
        int b;
        mode = 2; seed = int'($urandom_range(0, 999));
        mute_en = 1; mute_x = 8; mute_y = 0;
        clear_log();
        pulse_start();
        run_to_done("tmo");
        repeat (2) @(negedge clk);
        compare_frame("tmo");
        b = find_byte(12'(int'(BASE) + 12'h010));
        checks++; if (b < 0 || b[7] != 1'b0) begin errors++; $display("FAIL tmo_bit7: byte %0h, required bit7=0", b); end
        checks++; if (TimeoutErr !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b, required 1", TimeoutErr); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL tmo_donecnt: got %0d, required 1", done_cnt); end
        mute_en = 0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) begin
            mode = 2; seed = int'($urandom_range(0, 999)); mute_en = 0;
            clear_log();
            pulse_start();
            checks++; if (TimeoutErr !== 1'b0) begin errors++; $display("FAIL rand_tmo_clear: got %b, required 0", TimeoutErr); end
            run_to_done("rand");
            repeat (2) @(negedge clk);
            compare_frame("rand");
        end
    endtask

    task automatic test_abort();
        mode = 2; seed = int'($urandom_range(0, 999)); mute_en = 0;
        clear_log();
        pulse_start();
        wait_pixel("abort", 20, 3);
        FrameAbort = 1'b1;
        @(negedge clk);
        FrameAbort = 1'b0;
        checks++; if (SampleStart !== 1'b0) begin errors++; $display("FAIL abort_ss: got %b, required 0", SampleStart); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", Busy); end
        clear_log();
        repeat (100) @(negedge clk);
        checks++; if (wr_addr_q.size() != 0) begin
            errors++; $display("FAIL abort_wren: got %0d writes after abort, required 0", wr_addr_q.size());
        end
        pulse_start();
        checks++; if (PixelX !== 7'd0 || PixelY !== 7'd0 || Busy !== 1'b1) begin
            errors++; $display("FAIL abort_restart: got (%0d,%0d) busy=%b, required (0,0) busy=1", PixelX, PixelY, Busy);
        end
        run_to_done("abort_restart");
        repeat (2) @(negedge clk);
        compare_frame("abort_restart");
    endtask

    task automatic test_start_ignored();
        mode = 2; seed = int'($urandom_range(0, 999)); mute_en = 0;
        clear_log();
        pulse_start();
        wait_pixel("ign", 5, 1);
        pulse_start();
        checks++; if (Busy !== 1'b1 || PixelY === 7'd0) begin
            errors++; $display("FAIL ign_mid: busy=%b row=%0d, required busy=1 row>0", Busy, PixelY);
        end
        run_to_done("ign");
        repeat (2) @(negedge clk);
        compare_frame("ign");
        clear_log();
        pulse_start();
        repeat (50) @(negedge clk);
        FrameStart = 1'b1; FrameAbort = 1'b1;
        @(negedge clk);
        FrameStart = 1'b0; FrameAbort = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL both_busy: got %b, required 0", Busy); end
        repeat (5) @(negedge clk);
        checks++; if (Busy !== 1'b0 || SampleStart !== 1'b0) begin
            errors++; $display("FAIL both_idle: busy=%b ss=%b, required 0 0", Busy, SampleStart);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        mode = 0; mute_en = 0;
        clear_log();
        pulse_start();
        while (!(WrEn === 1'b1 && WrAddr[0] === 1'b0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (WrEn !== 1'b1) begin errors++; $display("FAIL rmid_reach: WrEn=%b, required 1", WrEn); end
        #1 rstn = 1'b0;
        #1;
        checks++; if (WrEn !== 1'b0 || SampleStart !== 1'b0 || Busy !== 1'b0 || FrameDone !== 1'b0) begin
            errors++; $display("FAIL rmid_outs: wren=%b ss=%b busy=%b done=%b, required all 0", WrEn, SampleStart, Busy, FrameDone);
        end
        checks++; if (PixelX !== 7'd0 || PixelY !== 7'd0) begin
            errors++; $display("FAIL rmid_pixel: got (%0d,%0d), required (0,0)", PixelX, PixelY);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rmid_after: busy=%b, required 0", Busy); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_const();
        test_timeout();
        test_random();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
